// File: rtl/shift_xor_accumulator_if.sv
// Word-set input, drain output and status signals for shift_xor_accumulator.
// The master modport is the side that produces word sets and consumes the drain stream.
interface shift_xor_accumulator_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_W     = 10
);
    localparam int unsigned ShiftW = $clog2(WORD_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] high_left;
    logic [WORD_WIDTH-1:0] high_right;
    logic [WORD_WIDTH-1:0] low_left;
    logic [WORD_WIDTH-1:0] low_right;
    logic [ShiftW-1:0]     bit_shift;
    logic [ADDR_W-1:0]     acc_addr;
    logic                  clear_start;
    logic                  drain_start;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  clear_done;
    logic                  drain_done;
    logic                  err_addr;

    modport master (
        output in_valid, high_left, high_right, low_left, low_right, bit_shift, acc_addr,
        output clear_start, drain_start, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, clear_done, drain_done, err_addr
    );

    modport slave (
        input  in_valid, high_left, high_right, low_left, low_right, bit_shift, acc_addr,
        input  clear_start, drain_start, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, clear_done, drain_done, err_addr
    );
endinterface

// File: rtl/shift_xor_accumulator.sv
// Funnel-shift/XOR accumulator. Each accepted word set is reduced to one contribution word
// that is read-modify-written into the accumulator array through a two-stage pipeline
// (S1 read, S2 write, with S2->S1 forwarding). CLEAR zeroes the array, DRAIN streams it out.
// Optional feature: define SHIFT_ACC_TAIL_MASK_EN to mask the last drained word to TAIL_BITS.
module shift_xor_accumulator #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ACC_WORDS  = 553,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned TAIL_BITS  = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    shift_xor_accumulator_if.slave bus
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ACC_WORDS - 1);
    localparam logic [ADDR_W:0]   AccLimit = (ADDR_W + 1)'(ACC_WORDS);

`ifdef SHIFT_ACC_TAIL_MASK_EN
    localparam logic [WORD_WIDTH-1:0] TailMask =
        (TAIL_BITS >= WORD_WIDTH) ? '1 : WORD_WIDTH'((64'd1 << TAIL_BITS) - 64'd1);
`else
    localparam logic [WORD_WIDTH-1:0] TailMask = '1;
`endif

    // Elaboration-time parameter sanity checks.
    if ((2 ** ADDR_W) < ACC_WORDS) begin : g_addr_w_check
        $error("ADDR_W too narrow for ACC_WORDS");
    end
    if (TAIL_BITS > WORD_WIDTH) begin : g_tail_bits_check
        $error("TAIL_BITS exceeds WORD_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StClear, StFlush, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
    logic [WORD_WIDTH-1:0] s1_contrib_q, s1_contrib_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0]     s2_addr_q, s2_addr_d;
    logic [WORD_WIDTH-1:0] s2_contrib_q, s2_contrib_d;
    logic [WORD_WIDTH-1:0] s2_rd_q, s2_rd_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  clear_done_q, clear_done_d;
    logic                  drain_done_q, drain_done_d;
    logic                  err_addr_q, err_addr_d;

    logic [WORD_WIDTH-1:0] mem [ACC_WORDS];

    logic                  in_ready;
    logic                  accept;
    logic                  addr_ok;
    logic                  pipe_busy;
    logic                  clear_we;
    logic [WORD_WIDTH-1:0] contrib;
    logic [WORD_WIDTH-1:0] s2_wdata;
    logic [ADDR_W-1:0]     rd_addr;
    logic [WORD_WIDTH-1:0] mem_rd;
    logic [WORD_WIDTH-1:0] drain_word;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    assign in_ready  = (state_q == StIdle) & ~bus.clear_start & ~bus.drain_start;
    assign accept    = bus.in_valid & in_ready;
    assign addr_ok   = {1'b0, bus.acc_addr} < AccLimit;
    assign pipe_busy = s1_valid_q | s2_valid_q;
    assign s2_wdata  = s2_rd_q ^ s2_contrib_q;

    // Funnel shift of each pair, low word kept, XOR of both pairs.
    assign contrib = WORD_WIDTH'({bus.high_left, bus.high_right} >> bus.bit_shift)
                   ^ WORD_WIDTH'({bus.low_left, bus.low_right} >> bus.bit_shift);

    // Single read port: drain pointer while streaming, otherwise the S1 address.
    assign rd_addr    = (state_q == StFlush || state_q == StDrain) ? ptr_q : s1_addr_q;
    assign mem_rd     = mem[rd_addr];
    assign drain_word = mem_rd & ((ptr_q == LastAddr) ? TailMask : '1);

    // Single write port: S2 commits and CLEAR never overlap (CLEAR waits for an empty pipe).
    always_comb begin
        mem_we    = s2_valid_q | clear_we;
        mem_waddr = s2_valid_q ? s2_addr_q : ptr_q;
        mem_wdata = s2_valid_q ? s2_wdata : '0;
    end

    // Accumulator array storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-modify-write pipeline next state; out-of-range transfers only raise err_addr.
    always_comb begin
        s1_valid_d   = accept & addr_ok;
        s1_addr_d    = s1_addr_q;
        s1_contrib_d = s1_contrib_q;
        if (accept && addr_ok) begin
            s1_addr_d    = bus.acc_addr;
            s1_contrib_d = contrib;
        end
        s2_valid_d   = s1_valid_q;
        s2_addr_d    = s1_addr_q;
        s2_contrib_d = s1_contrib_q;
        // Forward the word S2 is writing this cycle so S1 never sees a stale read.
        s2_rd_d      = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_wdata : mem_rd;
        err_addr_d   = err_addr_q | (accept & ~addr_ok);
    end

    // Control FSM next state: idle, clear sweep, pipeline flush, drain stream.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        clear_done_d = 1'b0;
        drain_done_d = 1'b0;
        clear_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ptr_d = '0;
                if (bus.clear_start) begin
                    state_d = StClear;
                end else if (bus.drain_start) begin
                    state_d = StFlush;
                end
            end
            StClear: begin
                if (!pipe_busy) begin
                    clear_we = 1'b1;
                    if (ptr_q == LastAddr) begin
                        clear_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            StFlush: begin
                if (!pipe_busy) begin
                    out_data_d  = drain_word;
                    out_valid_d = 1'b1;
                    out_last_d  = (ptr_q == LastAddr);
                    ptr_d       = ptr_q + ADDR_W'(1);
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        drain_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        out_data_d = drain_word;
                        out_last_d = (ptr_q == LastAddr);
                        ptr_d      = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pipeline and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_contrib_q <= '0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= '0;
            s2_contrib_q <= '0;
            s2_rd_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            clear_done_q <= 1'b0;
            drain_done_q <= 1'b0;
            err_addr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_contrib_q <= s1_contrib_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            s2_contrib_q <= s2_contrib_d;
            s2_rd_q      <= s2_rd_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            clear_done_q <= clear_done_d;
            drain_done_q <= drain_done_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = (state_q != StIdle) | pipe_busy;
    assign bus.clear_done = clear_done_q;
    assign bus.drain_done = drain_done_q;
    assign bus.err_addr   = err_addr_q;

endmodule
